// File: rtl/instr_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit_pkg
// Purpose  : Shared types and constants for the instruction fetch unit:
//            FSM state encoding, fetch buffer depth and counter widths.
// Revision : 1.0 - initial release
// ============================================================================
package instr_fetch_unit_pkg;

  // Depth of the decoupling buffer between memory and decode.
  localparam int BUF_DEPTH = 2;

  // Width able to hold a fill level of 0..BUF_DEPTH.
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  // Width of a read/write pointer into the buffer.
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  // Fetch sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,  // one settle cycle after reset
    ST_REQ   = 3'd1,  // read request outstanding
    ST_ADV   = 3'd2,  // pc update in flight, waiting for pc_addr to settle
    ST_HOLD  = 3'd3,  // buffer full, waiting for decode to drain
    ST_FLUSH = 3'd4   // request outstanding whose data is to be discarded
  } fetch_state_e;

  // True when the buffer cannot accept another word.
  function automatic logic buf_full(input logic [CNT_W-1:0] cnt);
    return cnt >= CNT_W'(BUF_DEPTH);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_buffer
// Purpose  : Small FIFO holding fetched {address, instruction} pairs for the
//            decode stage. Supports simultaneous push and pop, and a flush
//            that empties it in one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_buffer
  import instr_fetch_unit_pkg::*;
#(
  parameter int N = 32,
  parameter int W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [N+W-1:0]   push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic [N+W-1:0]   head
);

  logic [N+W-1:0]   entry_q [BUF_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic pop_ok;
  logic push_ok;

  // A pop on an empty buffer is ignored; a push is taken when there is room,
  // including room freed by a pop in the same cycle.
  always_comb begin
    pop_ok  = pop && (count_q != '0);
    push_ok = push && (!buf_full(count_q) || pop_ok);
  end

  // Storage, pointers and fill level; flush takes priority over push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q  <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        entry_q[wr_ptr_q] <= push_data;
        wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  assign count = count_q;
  assign head  = entry_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Fetches instructions at the program counter over a req/ack
//            memory handshake, buffers them for decode, and steers the
//            program counter with increment and load pulses (redirects).
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int N = 32,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  // program counter
  input  logic [N-1:0] pc_addr,
  output logic         pc_inc,
  output logic         pc_load,
  output logic [N-1:0] pc_data,
  // instruction memory
  output logic         mem_req,
  output logic [N-1:0] mem_addr,
  input  logic         mem_ack,
  input  logic [W-1:0] mem_rdata,
  // branch redirect
  input  logic         redirect,
  input  logic [N-1:0] redirect_addr,
  // decode
  output logic         ir_valid,
  output logic [W-1:0] ir_data,
  output logic [N-1:0] ir_pc,
  input  logic         ir_ready
);

  fetch_state_e state_q, state_d;
  // ADV takes two cycles: the first carries the pc_inc/pc_load pulse, the
  // second lets the counter's new value appear on pc_addr before it is used.
  logic         adv_bubble_q, adv_bubble_d;
  logic         mem_req_q, mem_req_d;
  logic [N-1:0] mem_addr_q, mem_addr_d;
  logic         pc_inc_q, pc_inc_d;
  logic         pc_load_q, pc_load_d;
  logic [N-1:0] pc_data_q, pc_data_d;

  logic             push_en;
  logic             pop_en;
  logic             flush_en;
  logic [CNT_W-1:0] buf_count;
  logic [N+W-1:0]   buf_head;
  logic             buf_is_full;

  assign buf_is_full = buf_full(buf_count);
  assign pop_en      = ir_valid && ir_ready;

  // Next-state, handshake and program-counter control.
  always_comb begin
    state_d      = state_q;
    adv_bubble_d = adv_bubble_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    pc_inc_d     = 1'b0;
    pc_load_d    = 1'b0;
    pc_data_d    = pc_data_q;
    push_en      = 1'b0;
    flush_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        state_d    = ST_REQ;
        mem_req_d  = 1'b1;
        mem_addr_d = pc_addr;
      end
      ST_REQ: begin
        if (mem_ack) begin
          push_en      = 1'b1;
          pc_inc_d     = 1'b1;
          mem_req_d    = 1'b0;
          state_d      = ST_ADV;
          adv_bubble_d = 1'b0;
        end
      end
      ST_ADV: begin
        if (!adv_bubble_q) begin
          adv_bubble_d = 1'b1;
        end else if (!buf_is_full) begin
          state_d    = ST_REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = pc_addr;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!buf_is_full) begin
          state_d    = ST_REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = pc_addr;
        end
      end
      ST_FLUSH: begin
        // The ack completes the discarded read; its data is never pushed.
        if (mem_ack) begin
          mem_req_d    = 1'b0;
          state_d      = ST_ADV;
          adv_bubble_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A redirect overrides whatever the state logic chose: it empties the
    // buffer, discards any same-cycle ack and loads the new target. A read
    // still in flight keeps its request/address until the memory answers,
    // so a redirect in FLUSH without an ack stays in FLUSH.
    if (redirect && (state_q != ST_IDLE)) begin
      flush_en   = 1'b1;
      push_en    = 1'b0;
      pc_inc_d   = 1'b0;
      pc_load_d  = 1'b1;
      pc_data_d  = redirect_addr;
      mem_addr_d = mem_addr_q;
      if (((state_q == ST_REQ) || (state_q == ST_FLUSH)) && !mem_ack) begin
        state_d   = ST_FLUSH;
        mem_req_d = 1'b1;
      end else begin
        state_d      = ST_ADV;
        adv_bubble_d = 1'b0;
        mem_req_d    = 1'b0;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      adv_bubble_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      pc_inc_q     <= 1'b0;
      pc_load_q    <= 1'b0;
      pc_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      adv_bubble_q <= adv_bubble_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      pc_inc_q     <= pc_inc_d;
      pc_load_q    <= pc_load_d;
      pc_data_q    <= pc_data_d;
    end
  end

  fetch_buffer #(
    .N (N),
    .W (W)
  ) u_fetch_buffer (
    .clk       (clk),
    .rst       (rst),
    .push      (push_en),
    .push_data ({mem_addr_q, mem_rdata}),
    .pop       (pop_en),
    .flush     (flush_en),
    .count     (buf_count),
    .head      (buf_head)
  );

  assign pc_inc   = pc_inc_q;
  assign pc_load  = pc_load_q;
  assign pc_data  = pc_data_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign ir_valid = (buf_count != '0);
  assign ir_data  = buf_head[W-1:0];
  assign ir_pc    = buf_head[N+W-1:W];

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Directed self-checking bench for instr_fetch_unit with a simple
//            program counter model and hand-driven memory acks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_addr;
  logic        pc_inc, pc_load;
  logic [31:0] pc_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        ir_valid;
  logic [31:0] ir_data, ir_pc;
  logic        ir_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.N(32), .W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_addr       (pc_addr),
    .pc_inc        (pc_inc),
    .pc_load       (pc_load),
    .pc_data       (pc_data),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .ir_valid      (ir_valid),
    .ir_data       (ir_data),
    .ir_pc         (ir_pc),
    .ir_ready      (ir_ready)
  );

  // Program counter model: reset to 0, load wins, otherwise increment.
  always_ff @(posedge clk) begin
    if (rst)          pc_addr <= '0;
    else if (pc_load) pc_addr <= pc_data;
    else if (pc_inc)  pc_addr <= pc_addr + 32'd1;
  end

  // Instruction word the memory returns for an address.
  function automatic logic [31:0] fdata(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic do_reset();
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    redirect = 1'b0; redirect_addr = '0; ir_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    redirect = 1'b0; redirect_addr = '0; ir_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (pc_inc !== 1'b0)    begin failures++; $display("FAIL reset_pc_inc got=%b exp=0", pc_inc); end
    checks++; if (pc_load !== 1'b0)   begin failures++; $display("FAIL reset_pc_load got=%b exp=0", pc_load); end
    checks++; if (pc_data !== 32'h0)  begin failures++; $display("FAIL reset_pc_data got=%h exp=0", pc_data); end
    checks++; if (mem_req !== 1'b0)   begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (ir_valid !== 1'b0)  begin failures++; $display("FAIL reset_ir_valid got=%b exp=0", ir_valid); end
    checks++; if (ir_data !== 32'h0)  begin failures++; $display("FAIL reset_ir_data got=%h exp=0", ir_data); end
    checks++; if (ir_pc !== 32'h0)    begin failures++; $display("FAIL reset_ir_pc got=%h exp=0", ir_pc); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1)   begin failures++; $display("FAIL reset_first_req got=%b exp=1", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_first_addr got=%h exp=0", mem_addr); end
  endtask

  // Immediate acks, decode always ready: one fetch every 3 cycles.
  task automatic test_sequential_fetch();
    logic [31:0] ei;
    do_reset();
    ir_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      ei = 32'(k / 3);
      case (k % 3)
        0: begin
          checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL seq_req k=%0d got=%b exp=1", k, mem_req); end
          checks++; if (mem_addr !== ei)  begin failures++; $display("FAIL seq_addr k=%0d got=%h exp=%h", k, mem_addr, ei); end
          checks++; if (pc_inc !== 1'b0)  begin failures++; $display("FAIL seq_inc0 k=%0d got=%b exp=0", k, pc_inc); end
        end
        1: begin
          checks++; if (pc_inc !== 1'b1)      begin failures++; $display("FAIL seq_inc k=%0d got=%b exp=1", k, pc_inc); end
          checks++; if (mem_req !== 1'b0)     begin failures++; $display("FAIL seq_req_drop k=%0d got=%b exp=0", k, mem_req); end
          checks++; if (ir_valid !== 1'b1)    begin failures++; $display("FAIL seq_valid k=%0d got=%b exp=1", k, ir_valid); end
          checks++; if (ir_pc !== ei)         begin failures++; $display("FAIL seq_ir_pc k=%0d got=%h exp=%h", k, ir_pc, ei); end
          checks++; if (ir_data !== fdata(ei)) begin failures++; $display("FAIL seq_ir_data k=%0d got=%h exp=%h", k, ir_data, fdata(ei)); end
        end
        default: begin
          checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL seq_popped k=%0d got=%b exp=0", k, ir_valid); end
          checks++; if (pc_inc !== 1'b0)   begin failures++; $display("FAIL seq_inc2 k=%0d got=%b exp=0", k, pc_inc); end
        end
      endcase
      mem_ack = mem_req; mem_rdata = fdata(mem_addr);
      @(negedge clk);
    end
    mem_ack = 1'b0;
  endtask

  // Decode stalled: two fetches fill the buffer, then HOLD until one pop.
  task automatic test_backpressure();
    int incs;
    incs = 0;
    do_reset();
    for (int k = 0; k <= 10; k++) begin
      if (pc_inc === 1'b1) incs++;
      case (k)
        0: begin
          checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL bp_addr0 got=%h exp=0", mem_addr); end
        end
        3: begin
          checks++; if (mem_addr !== 32'h1) begin failures++; $display("FAIL bp_addr1 got=%h exp=1", mem_addr); end
        end
        6, 7, 8: begin
          checks++; if (mem_req !== 1'b0)  begin failures++; $display("FAIL bp_hold_req k=%0d got=%b exp=0", k, mem_req); end
          checks++; if (ir_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid k=%0d got=%b exp=1", k, ir_valid); end
          checks++; if (ir_pc !== 32'h0)   begin failures++; $display("FAIL bp_hold_pc k=%0d got=%h exp=0", k, ir_pc); end
        end
        9: begin
          checks++; if (mem_req !== 1'b0)       begin failures++; $display("FAIL bp_pop_req got=%b exp=0", mem_req); end
          checks++; if (ir_pc !== 32'h1)        begin failures++; $display("FAIL bp_pop_pc got=%h exp=1", ir_pc); end
          checks++; if (ir_data !== fdata(32'h1)) begin failures++; $display("FAIL bp_pop_data got=%h exp=%h", ir_data, fdata(32'h1)); end
        end
        10: begin
          checks++; if (mem_req !== 1'b1)   begin failures++; $display("FAIL bp_resume_req got=%b exp=1", mem_req); end
          checks++; if (mem_addr !== 32'h2) begin failures++; $display("FAIL bp_resume_addr got=%h exp=2", mem_addr); end
        end
        default: ;
      endcase
      mem_ack = mem_req; mem_rdata = fdata(mem_addr); ir_ready = (k == 8);
      @(negedge clk);
    end
    mem_ack = 1'b0; ir_ready = 1'b0;
    checks++; if (incs != 2) begin failures++; $display("FAIL bp_fetch_count got=%0d exp=2", incs); end
  endtask

  // Redirect while a request waits: request held, data dropped, refetch at target.
  task automatic test_redirect_pending();
    do_reset();
    ir_ready = 1'b1;
    redirect = 1'b1; redirect_addr = 32'h100;
    @(negedge clk);
    redirect = 1'b0;
    checks++; if (pc_load !== 1'b1)      begin failures++; $display("FAIL rp_load got=%b exp=1", pc_load); end
    checks++; if (pc_data !== 32'h100)   begin failures++; $display("FAIL rp_data got=%h exp=100", pc_data); end
    checks++; if (pc_inc !== 1'b0)       begin failures++; $display("FAIL rp_inc got=%b exp=0", pc_inc); end
    checks++; if (mem_req !== 1'b1)      begin failures++; $display("FAIL rp_req1 got=%b exp=1", mem_req); end
    checks++; if (mem_addr !== 32'h0)    begin failures++; $display("FAIL rp_addr1 got=%h exp=0", mem_addr); end
    @(negedge clk);
    checks++; if (pc_load !== 1'b0)      begin failures++; $display("FAIL rp_load_pulse got=%b exp=0", pc_load); end
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin failures++; $display("FAIL rp_hold got=%b/%h exp=1/0", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++; if (mem_req !== 1'b0)      begin failures++; $display("FAIL rp_req_drop got=%b exp=0", mem_req); end
    checks++; if (ir_valid !== 1'b0)     begin failures++; $display("FAIL rp_dropped got=%b exp=0", ir_valid); end
    checks++; if (pc_inc !== 1'b0)       begin failures++; $display("FAIL rp_no_inc got=%b exp=0", pc_inc); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (mem_req !== 1'b1)      begin failures++; $display("FAIL rp_refetch_req got=%b exp=1", mem_req); end
    checks++; if (mem_addr !== 32'h100)  begin failures++; $display("FAIL rp_refetch_addr got=%h exp=100", mem_addr); end
    mem_ack = 1'b1; mem_rdata = fdata(32'h100);
    @(negedge clk);
    mem_ack = 1'b0;
    checks++; if (ir_valid !== 1'b1 || ir_pc !== 32'h100) begin failures++; $display("FAIL rp_target_ir got=%b/%h exp=1/100", ir_valid, ir_pc); end
    checks++; if (pc_inc !== 1'b1)       begin failures++; $display("FAIL rp_target_inc got=%b exp=1", pc_inc); end
  endtask

  // Redirect, ack and pop all in one cycle.
  task automatic test_redirect_ack_pop();
    do_reset();
    mem_ack = 1'b1; mem_rdata = fdata(32'h0);
    @(negedge clk);
    mem_ack = 1'b0;
    checks++; if (ir_valid !== 1'b1) begin failures++; $display("FAIL rap_pre_valid got=%b exp=1", ir_valid); end
    repeat (2) @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h1) begin failures++; $display("FAIL rap_pre_req got=%b/%h exp=1/1", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = fdata(32'h1);
    redirect = 1'b1; redirect_addr = 32'h200; ir_ready = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0; redirect = 1'b0; ir_ready = 1'b0;
    checks++; if (ir_valid !== 1'b0)    begin failures++; $display("FAIL rap_flushed got=%b exp=0", ir_valid); end
    checks++; if (pc_load !== 1'b1)     begin failures++; $display("FAIL rap_load got=%b exp=1", pc_load); end
    checks++; if (pc_data !== 32'h200)  begin failures++; $display("FAIL rap_data got=%h exp=200", pc_data); end
    checks++; if (pc_inc !== 1'b0)      begin failures++; $display("FAIL rap_no_inc got=%b exp=0", pc_inc); end
    checks++; if (mem_req !== 1'b0)     begin failures++; $display("FAIL rap_req got=%b exp=0", mem_req); end
    @(negedge clk);
    checks++; if (pc_inc !== 1'b0 || ir_valid !== 1'b0) begin failures++; $display("FAIL rap_quiet got=%b/%b exp=0/0", pc_inc, ir_valid); end
    @(negedge clk);
    checks++; if (mem_req !== 1'b1)     begin failures++; $display("FAIL rap_refetch_req got=%b exp=1", mem_req); end
    checks++; if (mem_addr !== 32'h200) begin failures++; $display("FAIL rap_refetch_addr got=%h exp=200", mem_addr); end
  endtask

  // Fetch at the top address; the counter wraps to 0 afterwards.
  task automatic test_wrap();
    do_reset();
    ir_ready = 1'b1;
    redirect = 1'b1; redirect_addr = 32'hFFFF_FFFF;
    @(negedge clk);
    redirect = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h0;
    @(negedge clk);
    mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_req got=%b/%h exp=1/ffffffff", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = fdata(32'hFFFF_FFFF);
    @(negedge clk);
    mem_ack = 1'b0;
    checks++; if (ir_pc !== 32'hFFFF_FFFF)        begin failures++; $display("FAIL wrap_ir_pc got=%h exp=ffffffff", ir_pc); end
    checks++; if (ir_data !== fdata(32'hFFFF_FFFF)) begin failures++; $display("FAIL wrap_ir_data got=%h exp=%h", ir_data, fdata(32'hFFFF_FFFF)); end
    checks++; if (pc_inc !== 1'b1)                begin failures++; $display("FAIL wrap_inc got=%b exp=1", pc_inc); end
    repeat (2) @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin failures++; $display("FAIL wrap_next got=%b/%h exp=1/0", mem_req, mem_addr); end
  endtask

  // Reset pulse mid-request with data buffered and an ack in the same cycle.
  task automatic test_reset_midop();
    do_reset();
    mem_ack = 1'b1; mem_rdata = fdata(32'h0);
    @(negedge clk);
    mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (mem_addr !== 32'h1 || ir_valid !== 1'b1) begin failures++; $display("FAIL rm_pre got=%h/%b exp=1/1", mem_addr, ir_valid); end
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = fdata(32'h1);
    @(negedge clk);
    rst = 1'b0; mem_ack = 1'b0;
    checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin failures++; $display("FAIL rm_mem got=%b/%h exp=0/0", mem_req, mem_addr); end
    checks++; if (pc_inc !== 1'b0 || pc_load !== 1'b0 || pc_data !== 32'h0) begin failures++; $display("FAIL rm_pc got=%b/%b/%h exp=0/0/0", pc_inc, pc_load, pc_data); end
    checks++; if (ir_valid !== 1'b0 || ir_pc !== 32'h0 || ir_data !== 32'h0) begin failures++; $display("FAIL rm_ir got=%b/%h/%h exp=0/0/0", ir_valid, ir_pc, ir_data); end
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin failures++; $display("FAIL rm_restart got=%b/%h exp=1/0", mem_req, mem_addr); end
    checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL rm_restart_valid got=%b exp=0", ir_valid); end
  endtask

  initial begin
    test_reset();
    test_sequential_fetch();
    test_backpressure();
    test_redirect_pending();
    test_redirect_ack_pop();
    test_wrap();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Upper bound on run time.
  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
